// File: rtl/snes_joypad_if.sv
// SNES joypad port bundle: pad inputs, $4016 serial port, auto-read.
// master drives pad/CPU strobes; slave (joypad) returns data/status.
interface snes_joypad_if;
  logic        pad_connect;
  logic [15:0] pad_buttons;
  logic        latch_wr;
  logic        latch_val;
  logic        rd_strobe;
  logic        rd_data;
  logic        auto_en;
  logic        vblank_start;
  logic        auto_busy;
  logic [15:0] joy1;
  logic        latch_out;

  modport master (
    output pad_connect,
    output pad_buttons,
    output latch_wr,
    output latch_val,
    output rd_strobe,
    output auto_en,
    output vblank_start,
    input  rd_data,
    input  auto_busy,
    input  joy1,
    input  latch_out
  );

  modport slave (
    input  pad_connect,
    input  pad_buttons,
    input  latch_wr,
    input  latch_val,
    input  rd_strobe,
    input  auto_en,
    input  vblank_start,
    output rd_data,
    output auto_busy,
    output joy1,
    output latch_out
  );
endinterface

// File: rtl/snes_joypad.sv
// DUALSHOCK-to-SNES joypad: $4016 latch/serial shift plus auto-read.
// Ports: clk, reset (sync, active-high), bus (snes_joypad_if.slave).
module snes_joypad #(
  parameter int AUTO_STEP = 16
) (
  input  logic          clk,
  input  logic          reset,
  snes_joypad_if.slave  bus
);

  localparam logic [7:0] DIV_LAST = 8'(AUTO_STEP - 1);

  typedef enum logic {
    ST_IDLE,
    ST_AUTO
  } state_t;

  state_t      state;
  logic [15:0] m;
  logic [15:0] p;
  logic [15:0] sr;
  logic [15:0] acc;
  logic [15:0] joy1_q;
  logic [7:0]  div;
  logic [3:0]  bit_cnt;
  logic        busy;
  logic        latch_q;

  // SNES order: B Y SEL START U D L R A X L R 0000
  always_comb begin
    p = ~bus.pad_buttons;
    m = 16'h0000;
    if (bus.pad_connect)
      m = {p[14], p[15], p[0], p[3],
           p[4], p[6], p[7], p[5],
           p[13], p[12],
           p[10] | p[8],
           p[11] | p[9],
           4'b0000};
  end

  assign bus.rd_data   = bus.pad_connect & sr[15];
  assign bus.auto_busy = busy;
  assign bus.joy1      = joy1_q;
  assign bus.latch_out = latch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      latch_q <= 1'b0;
      sr      <= 16'hFFFF;
      acc     <= 16'h0000;
      joy1_q  <= 16'h0000;
      div     <= 8'd0;
      bit_cnt <= 4'd0;
      busy    <= 1'b0;
    end else begin
      // Latch writes always land; their reload
      // effect is gated by the idle state below.
      if (bus.latch_wr)
        latch_q <= bus.latch_val;
      unique case (state)
        ST_IDLE: begin
          if (bus.vblank_start && bus.auto_en) begin
            state   <= ST_AUTO;
            busy    <= 1'b1;
            sr      <= m;
            acc     <= 16'h0000;
            div     <= 8'd0;
            bit_cnt <= 4'd0;
          end else if (latch_q) begin
            sr <= m;
          end else if (bus.rd_strobe) begin
            sr <= {sr[14:0], 1'b1};
          end
        end
        ST_AUTO: begin
          if (div == DIV_LAST) begin
            div     <= 8'd0;
            acc     <= {acc[14:0], sr[15]};
            sr      <= {sr[14:0], 1'b1};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              joy1_q <= {acc[14:0], sr[15]};
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
